// File: rtl/board_move_controller_if.sv
// Player-command and board-status bundle between input logic, the board controller and the screen drawer.
// master drives the command pulses and observes the board; slave is the controller.
interface board_move_controller_if;
  logic                 move_left;
  logic                 move_right;
  logic                 drop;
  logic                 frame_start;
  logic [0:5][0:6][1:0] tiles;
  logic [2:0]           cursor_col;
  logic [1:0]           cur_player;
  logic                 busy;
  logic                 move_done;
  logic                 reject;
  logic                 board_full;
  logic [5:0]           move_count;
  logic                 timeout;

  modport master (
    output move_left, move_right, drop, frame_start,
    input  tiles, cursor_col, cur_player, busy, move_done, reject,
           board_full, move_count, timeout
  );

  modport slave (
    input  move_left, move_right, drop, frame_start,
    output tiles, cursor_col, cur_player, busy, move_done, reject,
           board_full, move_count, timeout
  );
endinterface

// File: rtl/board_move_controller.sv
// Connect-4 board owner: cursor, column scan (1-6 cycles) and commit on the next frame_start; all outputs registered.
// Commands arriving while busy or full are dropped, never queued. Optional turn auto-pass timer: TURN_TIMER_EN.
module board_move_controller #(
  parameter int START_COL    = 3,
  parameter int FIRST_PLAYER = 1
`ifdef TURN_TIMER_EN
  ,
  parameter int TURN_FRAMES  = 600
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  board_move_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_FRAME, FULL} state_t;
  typedef logic [0:5][0:6][1:0] board_t;

  localparam logic [2:0] START_C    = 3'(START_COL);
  localparam logic [1:0] FIRST_P    = 2'(FIRST_PLAYER);
  localparam logic [2:0] LAST_COL   = 3'd6;
  localparam logic [2:0] BOTTOM_ROW = 3'd5;
  localparam logic [5:0] LAST_MOVE  = 6'd41;

  state_t     state_q, state_d;
  board_t     tiles_q, tiles_d;
  logic [2:0] cursor_q, cursor_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [1:0] player_q, player_d;
  logic [5:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       move_done_q, move_done_d;
  logic       reject_q, reject_d;
  logic       full_q, full_d;

`ifdef TURN_TIMER_EN
  localparam int FCW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(TURN_FRAMES - 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           timeout_q, timeout_d;
`endif

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == 2'd1) ? 2'd2 : 2'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    tiles_d     = tiles_q;
    cursor_d    = cursor_q;
    col_d       = col_q;
    row_d       = row_q;
    player_d    = player_q;
    count_d     = count_q;
    full_d      = full_q;
    move_done_d = 1'b0;
    reject_d    = 1'b0;
`ifdef TURN_TIMER_EN
    fcnt_d      = fcnt_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.drop) begin
          col_d   = cursor_q;
          row_d   = BOTTOM_ROW;
          state_d = SCAN;
        end else begin
          if (bus.move_left && !bus.move_right && cursor_q != 3'd0) begin
            cursor_d = cursor_q - 3'd1;
          end else if (bus.move_right && !bus.move_left && cursor_q != LAST_COL) begin
            cursor_d = cursor_q + 3'd1;
          end
`ifdef TURN_TIMER_EN
          // Auto-pass overrides any cursor move in the same cycle.
          if (bus.frame_start) begin
            if (fcnt_q == FC_LAST) begin
              player_d  = other_player(player_q);
              cursor_d  = START_C;
              timeout_d = 1'b1;
              fcnt_d    = '0;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
`endif
        end
      end

      SCAN: begin
        if (tiles_q[row_q][col_q] == 2'd0) begin
          state_d = WAIT_FRAME;
        end else if (row_q == 3'd0) begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end else begin
          row_d = row_q - 3'd1;
        end
      end

      WAIT_FRAME: begin
        if (bus.frame_start) begin
          tiles_d[row_q][col_q] = player_q;
          count_d     = count_q + 6'd1;
          player_d    = other_player(player_q);
          cursor_d    = START_C;
          move_done_d = 1'b1;
`ifdef TURN_TIMER_EN
          fcnt_d      = '0;
`endif
          if (count_q == LAST_MOVE) begin
            full_d  = 1'b1;
            state_d = FULL;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FULL: begin
        state_d = FULL;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SCAN) || (state_d == WAIT_FRAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tiles_q     <= '0;
      cursor_q    <= START_C;
      col_q       <= '0;
      row_q       <= '0;
      player_q    <= FIRST_P;
      count_q     <= '0;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
      reject_q    <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tiles_q     <= tiles_d;
      cursor_q    <= cursor_d;
      col_q       <= col_d;
      row_q       <= row_d;
      player_q    <= player_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      move_done_q <= move_done_d;
      reject_q    <= reject_d;
      full_q      <= full_d;
    end
  end

`ifdef TURN_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.tiles      = tiles_q;
  assign bus.cursor_col = cursor_q;
  assign bus.cur_player = player_q;
  assign bus.busy       = busy_q;
  assign bus.move_done  = move_done_q;
  assign bus.reject     = reject_q;
  assign bus.board_full = full_q;
  assign bus.move_count = count_q;

endmodule

// File: tb/tb_board_move_controller.sv
// Directed bench for board_move_controller: inputs driven and outputs sampled on the falling clock edge.
// Build with TURN_TIMER_EN defined to exercise the turn timer with TURN_FRAMES=4.
module tb_board_move_controller;
  typedef logic [0:5][0:6][1:0] board_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     checks = 0;
  int     errors = 0;
  board_t exp_tiles;

  always #5 clk = ~clk;

  board_move_controller_if bm_if ();

  board_move_controller #(
    .START_COL    (3),
    .FIRST_PLAYER (1)
`ifdef TURN_TIMER_EN
    ,
    .TURN_FRAMES  (4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm_if)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected inputs for exactly one rising edge.
  task automatic pulse(input bit l, input bit r, input bit d, input bit f);
    bm_if.move_left   = l;
    bm_if.move_right  = r;
    bm_if.drop        = d;
    bm_if.frame_start = f;
    cyc(1);
    bm_if.move_left   = 1'b0;
    bm_if.move_right  = 1'b0;
    bm_if.drop        = 1'b0;
    bm_if.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    bm_if.move_left   = 1'b0;
    bm_if.move_right  = 1'b0;
    bm_if.drop        = 1'b0;
    bm_if.frame_start = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    exp_tiles = '0;
  endtask

  // Cursor is at column 3 whenever this is called.
  task automatic move_to(input int c);
    for (int i = c; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < c; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic commit(input int c, input logic [1:0] p, input int row);
    move_to(c);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(7);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    exp_tiles[row][c] = p;
    check("commit_move_done", bm_if.move_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic saw_reject;
    int   k;

    // Reset state
    do_reset();
    check("rst_tiles", bm_if.tiles, '0);
    check("rst_cursor", bm_if.cursor_col, 3);
    check("rst_player", bm_if.cur_player, 1);
    check("rst_count", bm_if.move_count, 0);
    check("rst_busy", bm_if.busy, 0);
    check("rst_flags", {bm_if.move_done, bm_if.reject, bm_if.board_full, bm_if.timeout}, 4'b0000);

    // First drop, frame_start ten cycles later
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("drop_busy", bm_if.busy, 1);
    cyc(10);
    check("wait_tiles_unchanged", bm_if.tiles, '0);
    check("wait_no_done", bm_if.move_done, 0);
    pulse(1'b0, 1'b0, 0, 1'b1);
    exp_tiles[5][3] = 2'd1;
    check("first_move_done", bm_if.move_done, 1);
    check("first_tiles", bm_if.tiles, exp_tiles);
    check("first_player", bm_if.cur_player, 2);
    check("first_count", bm_if.move_count, 1);
    check("first_busy", bm_if.busy, 0);
    cyc(1);
    check("first_done_one_cycle", bm_if.move_done, 0);

    // Fill column 3, then a seventh drop is rejected on cycle 7
    commit(3, 2'd2, 4);
    commit(3, 2'd1, 3);
    commit(3, 2'd2, 2);
    commit(3, 2'd1, 1);
    commit(3, 2'd2, 0);
    check("col3_tiles", bm_if.tiles, exp_tiles);
    check("col3_count", bm_if.move_count, 6);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    saw_reject = 1'b0;
    for (int i = 1; i < 6; i++) begin
      saw_reject |= bm_if.reject;
      cyc(1);
    end
    saw_reject |= bm_if.reject;
    check("reject_not_early", saw_reject, 0);
    cyc(1);
    check("reject_cycle7", bm_if.reject, 1);
    cyc(1);
    check("reject_one_cycle", bm_if.reject, 0);
    check("reject_tiles", bm_if.tiles, exp_tiles);
    check("reject_count", bm_if.move_count, 6);
    check("reject_player", bm_if.cur_player, 1);
    check("reject_busy", bm_if.busy, 0);

    // Cursor saturation, simultaneous moves, moves while busy
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("cursor_sat_right", bm_if.cursor_col, 6);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("cursor_both", bm_if.cursor_col, 6);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("cursor_busy_ignored", bm_if.cursor_col, 6);
    check("cursor_busy", bm_if.busy, 1);
    cyc(2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    exp_tiles[5][6] = 2'd1;
    check("col6_tiles", bm_if.tiles, exp_tiles);
    check("col6_player", bm_if.cur_player, 2);
    check("col6_cursor_home", bm_if.cursor_col, 3);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("cursor_sat_left", bm_if.cursor_col, 0);

    // Long wait without frame_start, then async reset mid-wait
    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1000);
    check("long_wait_busy", bm_if.busy, 1);
    check("long_wait_tiles", bm_if.tiles, '0);
    check("long_wait_count", bm_if.move_count, 0);
    rst_n = 1'b0;
    #1;
    check("abort_tiles", bm_if.tiles, '0);
    check("abort_busy", bm_if.busy, 0);
    check("abort_player", bm_if.cur_player, 1);
    check("abort_cursor", bm_if.cursor_col, 3);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_no_commit", bm_if.tiles, '0);

    // Fill the whole board column by column
    do_reset();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (k == 41) check("full_not_yet", bm_if.board_full, 0);
        commit(c, (k % 2 == 0) ? 2'd1 : 2'd2, 5 - i);
        k++;
      end
    end
    check("full_tiles", bm_if.tiles, exp_tiles);
    check("full_count", bm_if.move_count, 42);
    check("full_flag", bm_if.board_full, 1);
    check("full_busy", bm_if.busy, 0);
    check("full_player", bm_if.cur_player, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    saw_reject = 1'b0;
    for (int i = 0; i < 10; i++) begin
      saw_reject |= bm_if.reject | bm_if.busy;
      cyc(1);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    check("full_drop_ignored", saw_reject, 0);
    check("full_tiles_held", bm_if.tiles, exp_tiles);
    check("full_count_held", bm_if.move_count, 42);
    check("full_cursor_held", bm_if.cursor_col, 3);
    check("full_flag_sticky", bm_if.board_full, 1);

    // Turn timer
    do_reset();
`ifdef TURN_TIMER_EN
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      check("timer_no_timeout", bm_if.timeout, 0);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("timer_timeout", bm_if.timeout, 1);
    check("timer_player", bm_if.cur_player, 2);
    check("timer_cursor", bm_if.cursor_col, 3);
    cyc(1);
    check("timer_one_cycle", bm_if.timeout, 0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    check("timer_drop_wins", bm_if.timeout, 0);
    check("timer_drop_busy", bm_if.busy, 1);
    check("timer_drop_player", bm_if.cur_player, 2);
    cyc(1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    exp_tiles[5][3] = 2'd2;
    check("timer_commit_tiles", bm_if.tiles, exp_tiles);
    check("timer_commit_player", bm_if.cur_player, 1);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("timer_cleared_on_commit", bm_if.timeout, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("timer_second_timeout", bm_if.timeout, 1);
    check("timer_second_player", bm_if.cur_player, 2);
`else
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      check("no_timer_timeout", bm_if.timeout, 0);
    end
    check("no_timer_player", bm_if.cur_player, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
